// File: rtl/pixel_plot_sink.sv
// pixel_plot_sink: buffers pixel plots from a drawing engine in a small FIFO
// and drains them into a framebuffer through a registered write port with
// valid/ready (mem_we/mem_ready) handshaking.
// Optional feature macro: PLOT_CLIP_EN -- off-screen plots are dropped and
// counted in clip_count (saturating) instead of being written.
module pixel_plot_sink #(
    parameter int FIFO_DEPTH = 4,
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  x,
    input  logic [6:0]  y,
    input  logic [2:0]  color,
    input  logic        plot,
    output logic        plot_ready,
    output logic [14:0] mem_addr,
    output logic [2:0]  mem_data,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic        overflow,
    output logic [7:0]  clip_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef PLOT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    // FIFO storage and bookkeeping
    logic [14:0]      r_fifo_addr [FIFO_DEPTH];
    logic [2:0]       r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Output stage
    logic             r_mem_we;
    logic [14:0]      r_mem_addr;
    logic [2:0]       r_mem_data;
    logic             r_overflow;

    logic             w_ready;
    logic             w_off_screen;
    logic             w_in_range;
    logic             w_push;
    logic             w_pop;
    logic [14:0]      w_addr;

    // Space is judged from the registered count only, so a same-cycle pop
    // never makes room for a push.
    assign w_ready      = (r_count != FULL_CNT);
    assign w_off_screen = ({24'd0, x} >= 32'(SCREEN_W)) || ({25'd0, y} >= 32'(SCREEN_H));
    assign w_in_range   = !(CLIP_EN && w_off_screen);
    // Address arithmetic is done directly at 15 bits, so wider results wrap.
    assign w_addr       = (15'(y) * 15'(SCREEN_W)) + 15'(x);
    assign w_push       = plot && w_ready && w_in_range;
    assign w_pop        = (r_count != ZERO_CNT) && (!r_mem_we || mem_ready);

    assign plot_ready = w_ready;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_data   = r_mem_data;
    assign overflow   = r_overflow;

    // FIFO payload write; contents need no reset since pointers gate reads.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= w_addr;
            r_fifo_data[r_wr_ptr] <= color;
        end
    end

    // FIFO pointers and occupancy; power-of-two depth lets pointers wrap.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= ZERO_CNT;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Output stage: load the FIFO head when empty or completing, hold on stall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_mem_we   <= 1'b0;
            r_mem_addr <= 15'd0;
            r_mem_data <= 3'd0;
        end else if (w_pop) begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_fifo_addr[r_rd_ptr];
            r_mem_data <= r_fifo_data[r_rd_ptr];
        end else if (r_mem_we && mem_ready) begin
            r_mem_we   <= 1'b0;
        end else begin
            r_mem_we   <= r_mem_we;
        end
    end

    // Sticky flag for plots refused because the FIFO was full.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_overflow <= 1'b0;
        end else if (plot && !w_ready) begin
            r_overflow <= 1'b1;
        end else begin
            r_overflow <= r_overflow;
        end
    end

`ifdef PLOT_CLIP_EN
    logic [7:0] r_clip_count;
    assign clip_count = r_clip_count;

    // Saturating count of off-screen plots, regardless of FIFO space.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_clip_count <= 8'd0;
        end else if (plot && w_off_screen && (r_clip_count != 8'd255)) begin
            r_clip_count <= r_clip_count + 8'd1;
        end else begin
            r_clip_count <= r_clip_count;
        end
    end
`else
    assign clip_count = 8'd0;
`endif

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Scoreboard bench for pixel_plot_sink: stimulus pushes expected writes into
// a queue; a negedge monitor compares every presented write against the head.
module tb_pixel_plot_sink;

    logic        clk = 1'b0;
    logic        resetn;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  color;
    logic        plot;
    logic        plot_ready;
    logic [14:0] mem_addr;
    logic [2:0]  mem_data;
    logic        mem_we;
    logic        mem_ready;
    logic        overflow;
    logic [7:0]  clip_count;

    int n_cmp = 0;
    int n_bad = 0;
    int n_writes = 0;
    logic [17:0] q[$];

    pixel_plot_sink #(.FIFO_DEPTH(4), .SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .resetn(resetn), .x(x), .y(y), .color(color), .plot(plot),
        .plot_ready(plot_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_we(mem_we), .mem_ready(mem_ready), .overflow(overflow),
        .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: every presented write must match the oldest expected entry,
    // both while stalled (hold) and when accepted.
    always @(negedge clk) begin
        if (resetn === 1'b1 && mem_we === 1'b1) begin
            check("write_expected", 32'(q.size() > 0), 32'd1);
            if (q.size() > 0) begin
                check("mem_addr", 32'(mem_addr), 32'(q[0][17:3]));
                check("mem_data", 32'(mem_data), 32'(q[0][2:0]));
                if (mem_ready) begin
                    void'(q.pop_front());
                    n_writes++;
                end
            end
        end
    end

    // One plot over one edge; exp_ready is the hand-computed plot_ready.
    task automatic do_plot(input int px, input int py, input logic [2:0] c, input logic exp_ready);
        logic inr;
        logic [14:0] a;
`ifdef PLOT_CLIP_EN
        inr = (px < 160) && (py < 120);
`else
        inr = 1'b1;
`endif
        a = 15'(py * 160 + px);
        x = 8'(px); y = 7'(py); color = c; plot = 1'b1;
        #1;
        check("plot_ready_at_plot", 32'(plot_ready), 32'(exp_ready));
        if (exp_ready && inr) q.push_back({a, c});
        @(posedge clk); #1;
        plot = 1'b0;
    endtask

    task automatic drain();
        mem_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (q.size() == 0 && mem_we === 1'b0) break;
            @(negedge clk);
        end
        check("drain_queue_empty", 32'(q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        resetn = 1'b0; plot = 1'b0; x = 8'd0; y = 7'd0; color = 3'd0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_plot_ready", 32'(plot_ready), 32'd1);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_clip_count", 32'(clip_count), 32'd0);

        // Single write and latency: plot at edge N, mem_we high after N+1.
        @(posedge clk); #1;
        mem_ready = 1'b1;
        w0 = n_writes;
        do_plot(5, 2, 3'd7, 1'b1);
        @(negedge clk);
        check("lat_we_after_N", 32'(mem_we), 32'd0);
        @(negedge clk);
        check("lat_we_after_N1", 32'(mem_we), 32'd1);
        check("single_addr", 32'(mem_addr), 32'd325);
        check("single_data", 32'(mem_data), 32'd7);
        @(negedge clk);
        check("single_pulse_end", 32'(mem_we), 32'd0);
        check("single_count", 32'(n_writes - w0), 32'd1);

        // Backpressure: output stage plus four FIFO entries, then overflow.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) do_plot(i, 0, 3'(i + 1), 1'b1);
        @(negedge clk);
        check("bp_full_ready", 32'(plot_ready), 32'd0);
        check("bp_no_overflow_yet", 32'(overflow), 32'd0);
        @(posedge clk); #1;
        do_plot(5, 0, 3'd6, 1'b0);
        @(negedge clk);
        check("bp_overflow", 32'(overflow), 32'd1);
        w0 = n_writes;
        drain();
        check("bp_write_count", 32'(n_writes - w0), 32'd5);
        check("bp_ready_again", 32'(plot_ready), 32'd1);

        // Stall hold: mem_ready toggles every cycle during a 3-write burst.
        @(posedge clk); #1;
        w0 = n_writes;
        mem_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    @(posedge clk); #1;
                    mem_ready = ~mem_ready;
                end
            end
            begin
                do_plot(10, 3, 3'd1, 1'b1);
                do_plot(11, 3, 3'd2, 1'b1);
                do_plot(12, 3, 3'd4, 1'b1);
            end
        join
        drain();
        check("stall_write_count", 32'(n_writes - w0), 32'd3);

        // Clipping boundaries.
        @(posedge clk); #1;
        w0 = n_writes;
        do_plot(160, 0, 3'd3, 1'b1);
        do_plot(0, 120, 3'd5, 1'b1);
        do_plot(159, 119, 3'd6, 1'b1);
        drain();
`ifdef PLOT_CLIP_EN
        check("clip_count", 32'(clip_count), 32'd2);
        check("clip_writes", 32'(n_writes - w0), 32'd1);
        for (int i = 0; i < 300; i++) do_plot(200, 5, 3'd1, 1'b1);
        @(negedge clk);
        check("clip_saturate", 32'(clip_count), 32'd255);
`else
        check("noclip_count", 32'(clip_count), 32'd0);
        check("noclip_writes", 32'(n_writes - w0), 32'd3);
`endif

        // Reset mid-burst with three entries in the FIFO.
        @(posedge clk); #1;
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) do_plot(20 + i, 7, 3'd2, 1'b1);
        resetn = 1'b0;
        q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        check("mid_rst_mem_we", 32'(mem_we), 32'd0);
        check("mid_rst_plot_ready", 32'(plot_ready), 32'd1);
        check("mid_rst_overflow", 32'(overflow), 32'd0);
        check("mid_rst_clip", 32'(clip_count), 32'd0);
        w0 = n_writes;
        mem_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("mid_rst_no_stale", 32'(n_writes - w0), 32'd0);

        // Post-reset sanity write.
        do_plot(1, 1, 3'd5, 1'b1);
        drain();
        check("post_rst_write", 32'(n_writes - w0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pixel_plot_sink.md
PIXEL_PLOT_SINK -- requirements
Module: pixel_plot_sink

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of buffered pixel writes (power of two, 2..16).
REQ-002 The block SHALL have parameter SCREEN_W, default 160, meaning the visible width in pixels.
REQ-003 The block SHALL have parameter SCREEN_H, default 120, meaning the visible height in pixels.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port x, input, 8 bits: pixel column from the drawing engine.
REQ-007 Port y, input, 7 bits: pixel row from the drawing engine.
REQ-008 Port color, input, 3 bits: pixel colour, RGB one bit each.
REQ-009 Port plot, input, 1 bit: a write request for the current x, y and color.
REQ-010 Port plot_ready, output, 1 bit: high when the FIFO can accept a write.
REQ-011 Port mem_addr, output, 15 bits: framebuffer word address.
REQ-012 Port mem_data, output, 3 bits: framebuffer write colour.
REQ-013 Port mem_we, output, 1 bit: framebuffer write request.
REQ-014 Port mem_ready, input, 1 bit: the framebuffer accepts the write this cycle.
REQ-015 Port overflow, output, 1 bit: sticky flag; a plot was refused because the FIFO was full.
REQ-016 Port clip_count, output, 8 bits: count of clipped pixels, saturating.

Function
REQ-017 plot_ready SHALL equal NOT full, taken from the registered FIFO count; a pop in the same cycle does not free space for a push.
REQ-018 A plot with plot_ready high and the pixel in range SHALL push {address, color} into the FIFO at that edge.
REQ-019 The address SHALL be y*SCREEN_W + x, computed at push time and 15 bits wide.
REQ-020 A plot with plot_ready low SHALL be discarded and SHALL set overflow at that edge.
REQ-021 Output register stage: mem_we, mem_addr and mem_data SHALL be registered outputs.
REQ-022 A write SHALL complete on an edge where mem_we and mem_ready are both high.
REQ-023 While mem_we is high and mem_ready is low, mem_addr and mem_data SHALL hold stable.
REQ-024 If the output stage is empty or completing, and the FIFO is non-empty, the head entry SHALL be popped into the output stage and mem_we SHALL be set.
REQ-025 If the output stage is completing and the FIFO is empty, mem_we SHALL clear.
REQ-026 Throughput SHALL be one write per cycle while mem_ready stays high.
REQ-027 Latency: a plot into an idle block at edge N SHALL appear as mem_we high after edge N+1.
REQ-028 Ordering: writes SHALL reach the memory in plot order.
REQ-029 A push and a pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-031 While resetn is low at an edge, the block SHALL apply: FIFO emptied, mem_we=0, mem_addr=0, mem_data=0, overflow=0, clip_count=0, and plot_ready=1 after that edge.
REQ-032 Reset SHALL take priority over plot, even mid-operation.
REQ-033 A pending, unaccepted write SHALL be abandoned on reset.

Configuration
REQ-034 With PLOT_CLIP_EN defined, a plot with x>=SCREEN_W or y>=SCREEN_H SHALL NOT be pushed.
REQ-035 With PLOT_CLIP_EN defined, each such plot SHALL increment clip_count, saturating at 255, independent of plot_ready.
REQ-036 Without PLOT_CLIP_EN, every plot is treated as in range, clip_count SHALL be tied to 0, and the address SHALL be truncated to 15 bits.

Verification
REQ-037 Single write: plot x=5, y=2, color=7 with mem_ready=1 -> one mem_we pulse, 2 cycles later, addr=325, data=7.
REQ-038 Backpressure: mem_ready=0 with 5 plots, x=0..4, y=0 -> plot_ready low after the 5th plot is taken (output stage plus 4 entries); a 6th plot sets overflow; release mem_ready -> addrs 0..4 in order.
REQ-039 Stall hold: mem_ready toggled 0/1 each cycle during a 3-write burst -> addr and data never change while mem_we=1 and mem_ready=0.
REQ-040 Clip (PLOT_CLIP_EN): plots at (160,0), (0,120) and (159,119) -> clip_count=2, one write, addr=19199.
REQ-041 Clip saturation: 300 out-of-range plots -> clip_count=255.
REQ-042 Reset mid-burst: resetn low while the FIFO holds 3 entries -> mem_we=0, plot_ready=1 next cycle, and no stale writes afterwards.
